// File: rtl/ct_lsu_dcache_data_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ct_lsu_dcache_data_ctrl_pkg : shared widths, depths and grant encoding
// Rev 1.0
// ============================================================================
package ct_lsu_dcache_data_ctrl_pkg;

    localparam int IDX_W         = 11;
    localparam int DATA_W        = 32;
    localparam int BE_W          = 4;
    localparam int FIFO_DEPTH    = 2;
    localparam int STARVE_THRESH = 3;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_LOAD  = 2'd1,
        GNT_STORE = 2'd2
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/ct_lsu_dcache_data_ctrl_if.sv
`default_nettype none
// ============================================================================
// ct_lsu_dcache_data_ctrl_if : load/store request, data array and response bus
// Rev 1.0
// ============================================================================
interface ct_lsu_dcache_data_ctrl_if;
    import ct_lsu_dcache_data_ctrl_pkg::*;

    logic              ld_req_vld;
    logic [IDX_W-1:0]  ld_req_idx;
    logic              ld_req_rdy;

    logic              st_req_vld;
    logic [IDX_W-1:0]  st_req_idx;
    logic [DATA_W-1:0] st_req_din;
    logic [BE_W-1:0]   st_req_be;
    logic              st_req_rdy;

    logic              data_gateclk_en;
    logic              data_sel_b;
    logic              data_gwen_b;
    logic [BE_W-1:0]   data_wen_b;
    logic [IDX_W-1:0]  data_idx;
    logic [DATA_W-1:0] data_din;
    logic [DATA_W-1:0] data_dout;

    logic              ld_rsp_vld;
    logic [DATA_W-1:0] ld_rsp_data;
    logic              ld_rsp_rdy;

    modport slave (
        input  ld_req_vld, ld_req_idx,
        input  st_req_vld, st_req_idx, st_req_din, st_req_be,
        input  data_dout, ld_rsp_rdy,
        output ld_req_rdy, st_req_rdy,
        output data_gateclk_en, data_sel_b, data_gwen_b, data_wen_b, data_idx, data_din,
        output ld_rsp_vld, ld_rsp_data
    );

    modport master (
        output ld_req_vld, ld_req_idx,
        output st_req_vld, st_req_idx, st_req_din, st_req_be,
        output data_dout, ld_rsp_rdy,
        input  ld_req_rdy, st_req_rdy,
        input  data_gateclk_en, data_sel_b, data_gwen_b, data_wen_b, data_idx, data_din,
        input  ld_rsp_vld, ld_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/ct_lsu_dcache_rsp_fifo.sv
`default_nettype none
// ============================================================================
// ct_lsu_dcache_rsp_fifo : 2-entry valid/ready load response buffer
// Rev 1.0
// ============================================================================
module ct_lsu_dcache_rsp_fifo
    import ct_lsu_dcache_data_ctrl_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push_vld,
    output logic                   push_rdy,
    input  wire logic [DATA_W-1:0] push_data,
    output logic                   pop_vld,
    input  wire logic              pop_rdy,
    output logic [DATA_W-1:0]      pop_data,
    output logic [1:0]             occupancy
);

    localparam logic [1:0] c_full = 2'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign push_rdy  = (r_count != c_full);
    assign pop_vld   = (r_count != 2'd0);
    // Empty head reads as zero so the response bus is quiet when idle.
    assign pop_data  = pop_vld ? r_mem[r_rd_ptr] : '0;
    assign occupancy = r_count;
    assign w_push    = push_vld & push_rdy;
    assign w_pop     = pop_vld & pop_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ct_lsu_dcache_data_ctrl.sv
`default_nettype none
// ============================================================================
// ct_lsu_dcache_data_ctrl : load/store arbiter for the dcache data array
// Optional LSU_DCACHE_STARVE_GUARD_EN lets a starved load win over stores. Rev 1.0
// ============================================================================
module ct_lsu_dcache_data_ctrl
    import ct_lsu_dcache_data_ctrl_pkg::*;
(
    input  wire logic                 forever_cpuclk,
    input  wire logic                 cpurst,
    ct_lsu_dcache_data_ctrl_if.slave  bus
);

    logic       r_inflight;
    logic [1:0] w_occ;
    logic [1:0] w_credit;
    logic       w_pop;
    logic       w_credit_ok;
    logic       w_st_active;
    logic       w_force_ld;
    logic       w_ld_rdy;
    logic       w_ld_grant;
    logic       w_st_grant;
    logic       w_push_rdy;
    grant_e     w_grant;

    // Credit counts every load that is accepted but not yet handed back.
    assign w_credit    = w_occ + {1'b0, r_inflight};
    assign w_pop       = bus.ld_rsp_vld & bus.ld_rsp_rdy;
    assign w_credit_ok = (w_credit < 2'd2) | ((w_credit == 2'd2) & w_pop);
    assign w_st_active = bus.st_req_vld & (bus.st_req_be != '0);

`ifdef LSU_DCACHE_STARVE_GUARD_EN
    localparam logic [1:0] c_starve_max = 2'(STARVE_THRESH);

    logic [1:0] r_starve_cnt;
    logic       w_ld_waiting;

    assign w_ld_waiting = bus.ld_req_vld & w_credit_ok;
    assign w_force_ld   = (r_starve_cnt == c_starve_max);

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_starve_cnt <= 2'd0;
        end else if (w_ld_grant) begin
            r_starve_cnt <= 2'd0;
        end else if (w_st_grant && w_ld_waiting && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + 2'd1;
        end
    end
`else
    assign w_force_ld = 1'b0;
`endif

    assign w_ld_rdy   = ~cpurst & w_credit_ok & (~w_st_active | w_force_ld);
    assign w_ld_grant = bus.ld_req_vld & w_ld_rdy;
    assign w_st_grant = ~cpurst & w_st_active & ~w_ld_grant;

    assign bus.ld_req_rdy = w_ld_rdy;
    // A zero-byte-enable store is accepted without touching the array.
    assign bus.st_req_rdy = ~cpurst & ~(w_st_active & w_ld_grant);

    always_comb begin
        w_grant = GNT_NONE;
        if (w_st_grant) begin
            w_grant = GNT_STORE;
        end else if (w_ld_grant) begin
            w_grant = GNT_LOAD;
        end
    end

    always_comb begin
        bus.data_gateclk_en = 1'b0;
        bus.data_sel_b      = 1'b1;
        bus.data_gwen_b     = 1'b1;
        bus.data_wen_b      = '1;
        bus.data_idx        = '0;
        bus.data_din        = '0;
        case (w_grant)
            GNT_STORE: begin
                bus.data_gateclk_en = 1'b1;
                bus.data_sel_b      = 1'b0;
                bus.data_gwen_b     = 1'b0;
                bus.data_wen_b      = ~bus.st_req_be;
                bus.data_idx        = bus.st_req_idx;
                bus.data_din        = bus.st_req_din;
            end
            GNT_LOAD: begin
                bus.data_gateclk_en = 1'b1;
                bus.data_sel_b      = 1'b0;
                bus.data_idx        = bus.ld_req_idx;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_ld_grant;
        end
    end

    ct_lsu_dcache_rsp_fifo u_rsp_fifo (
        .clk       (forever_cpuclk),
        .rst       (cpurst),
        .push_vld  (r_inflight),
        .push_rdy  (w_push_rdy),
        .push_data (bus.data_dout),
        .pop_vld   (bus.ld_rsp_vld),
        .pop_rdy   (bus.ld_rsp_rdy),
        .pop_data  (bus.ld_rsp_data),
        .occupancy (w_occ)
    );

    // The credit limit must always leave room for the returning read.
    a_push_room: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        r_inflight |-> w_push_rdy);

endmodule
`default_nettype wire

// File: tb/tb_ct_lsu_dcache_data_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ct_lsu_dcache_data_ctrl : scoreboard bench with array model and reference memory
// Rev 1.0
// ============================================================================
module tb_ct_lsu_dcache_data_ctrl;
    import ct_lsu_dcache_data_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ct_lsu_dcache_data_ctrl_if bus ();

    ct_lsu_dcache_data_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] arr     [2048];
    logic [31:0] ref_mem [2048];
    exp_t        q [$];
    int          outstanding = 0;
    bit          lat_chk  = 1'b0;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data array: byte-masked write, registered read.
    always @(posedge clk) begin
        if (!bus.data_sel_b) begin
            if (!bus.data_gwen_b) begin
                for (int b = 0; b < 4; b++)
                    if (!bus.data_wen_b[b]) arr[bus.data_idx][b*8 +: 8] <= bus.data_din[b*8 +: 8];
            end else begin
                bus.data_dout <= arr[bus.data_idx];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: spec-level acceptance rules, array command check, response scoreboard.
    always @(negedge clk) begin
        logic pop, st_act, ld_acc, st_acc;
        exp_t e;
        if (rst) begin
            check("rst_ld_req_rdy", bus.ld_req_rdy, 0);
            check("rst_st_req_rdy", bus.st_req_rdy, 0);
            check("rst_ld_rsp_vld", bus.ld_rsp_vld, 0);
            check("rst_ld_rsp_data", bus.ld_rsp_data, 0);
            check("rst_array_idle", {bus.data_gateclk_en, bus.data_sel_b, bus.data_gwen_b,
                  bus.data_wen_b, bus.data_idx, bus.data_din}, {3'b011, 4'hF, 11'd0, 32'd0});
            q.delete();
            outstanding = 0;
            hold_pend   = 1'b0;
        end else begin
            pop    = bus.ld_rsp_vld & bus.ld_rsp_rdy;
            st_act = bus.st_req_vld & (bus.st_req_be != 4'h0);
            ld_acc = bus.ld_req_vld & bus.ld_req_rdy;
            st_acc = bus.st_req_vld & bus.st_req_rdy;
            if (hold_pend) begin
                check("rsp_hold_vld", bus.ld_rsp_vld, 1);
                check("rsp_hold_data", bus.ld_rsp_data, hold_data);
            end
            hold_pend = bus.ld_rsp_vld & ~bus.ld_rsp_rdy;
            hold_data = bus.ld_rsp_data;
            if (bus.ld_req_vld && !st_act)
                check("ld_rdy_credit", bus.ld_req_rdy, (outstanding < 2) || (outstanding == 2 && pop));
`ifndef LSU_DCACHE_STARVE_GUARD_EN
            if (bus.ld_req_vld && st_act) check("ld_rdy_store_prio", bus.ld_req_rdy, 0);
`endif
            if (bus.st_req_vld && !st_act) check("st_be0_accept", bus.st_req_rdy, 1);
            if (ld_acc) check("single_access", st_acc & st_act, 0);
            if (st_acc && st_act) begin
                check("st_array_cmd", {bus.data_gateclk_en, bus.data_sel_b, bus.data_gwen_b,
                      bus.data_wen_b, bus.data_idx, bus.data_din},
                      {3'b100, ~bus.st_req_be, bus.st_req_idx, bus.st_req_din});
                for (int b = 0; b < 4; b++)
                    if (bus.st_req_be[b]) ref_mem[bus.st_req_idx][b*8 +: 8] = bus.st_req_din[b*8 +: 8];
            end else if (ld_acc) begin
                check("ld_array_cmd", {bus.data_gateclk_en, bus.data_sel_b, bus.data_gwen_b,
                      bus.data_wen_b, bus.data_idx}, {3'b101, 4'hF, bus.ld_req_idx});
                e.data = ref_mem[bus.ld_req_idx];
                e.cyc  = cyc;
                q.push_back(e);
                outstanding++;
            end else begin
                check("idle_array_cmd", {bus.data_gateclk_en, bus.data_sel_b, bus.data_gwen_b,
                      bus.data_wen_b, bus.data_idx, bus.data_din}, {3'b011, 4'hF, 11'd0, 32'd0});
            end
            if (bus.ld_rsp_vld) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", bus.ld_rsp_vld, 0);
                end else if (pop) begin
                    e = q.pop_front();
                    outstanding--;
                    check("rsp_data", bus.ld_rsp_data, e.data);
                    if (lat_chk) check("rsp_latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_req_vld = 1'b0;
        bus.st_req_vld = 1'b0;
        bus.st_req_be  = 4'h0;
    endtask

    task automatic drain();
        int n = 0;
        bus.ld_rsp_rdy = 1'b1;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_timeout", q.size(), 0);
        tick();
    endtask

    task automatic store(input logic [10:0] idx, input logic [31:0] din, input logic [3:0] be);
        bus.st_req_vld = 1'b1;
        bus.st_req_idx = idx;
        bus.st_req_din = din;
        bus.st_req_be  = be;
    endtask

    initial begin
        int acc, got, seen;
        for (int i = 0; i < 2048; i++) begin
            arr[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.data_dout  = 32'h0;
        bus.ld_req_idx = 11'h12;
        bus.ld_req_vld = 1'b1;
        store(11'h34, 32'h5555_5555, 4'hF);
        bus.ld_rsp_rdy = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle_inputs();
        tick();

        // Store then load at 0x155, one-cycle array latency plus FIFO stage.
        lat_chk = 1'b1;
        store(11'h155, 32'hDEAD_BEEF, 4'hF);
        tick();
        idle_inputs();
        bus.ld_req_vld = 1'b1;
        bus.ld_req_idx = 11'h155;
        tick();
        idle_inputs();
        drain();

        // Partial byte-enable merge.
        store(11'h020, 32'hAAAA_AAAA, 4'hF);
        tick();
        store(11'h020, 32'h1122_3344, 4'b0101);
        @(negedge clk);
        check("partial_wen_b", bus.data_wen_b, 4'b1010);
        tick();
        idle_inputs();
        bus.ld_req_vld = 1'b1;
        bus.ld_req_idx = 11'h020;
        tick();
        idle_inputs();
        drain();

        // Back-to-back loads at full rate.
        for (int i = 0; i < 8; i++) begin
            bus.ld_req_vld = 1'b1;
            bus.ld_req_idx = 11'(100 + i * 3);
            @(negedge clk);
            check("b2b_ld_rdy", bus.ld_req_rdy, 1);
            tick();
        end
        idle_inputs();
        drain();

        // Back-pressure: only two loads fit, then resume.
        lat_chk = 1'b0;
        bus.ld_rsp_rdy = 1'b0;
        bus.ld_req_vld = 1'b1;
        bus.ld_req_idx = 11'h020;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.ld_req_rdy) acc++;
            tick();
            bus.ld_req_idx = 11'($urandom_range(0, 2047));
        end
        check("stall_accepts", acc, 2);
        bus.ld_rsp_rdy = 1'b1;
        for (int c = 0; c < 20 && acc < 6; c++) begin
            @(negedge clk);
            if (bus.ld_req_rdy) acc++;
            tick();
            bus.ld_req_idx = 11'($urandom_range(0, 2047));
        end
        check("resume_accepts", acc, 6);
        idle_inputs();
        drain();

        // Continuous stores against a waiting load.
        lat_chk = 1'b1;
        bus.ld_req_vld = 1'b1;
        bus.ld_req_idx = 11'h300;
        got = 0;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            store(11'($urandom_range(0, 2047)), $urandom, 4'hF);
            @(negedge clk);
            if (bus.ld_req_rdy) got = c;
            tick();
        end
        idle_inputs();
`ifdef LSU_DCACHE_STARVE_GUARD_EN
        check("starve_grant_cycle", got, 4);
`else
        check("starve_no_grant", got, 0);
`endif
        drain();

        // Reset with one response buffered and one read in flight.
        lat_chk = 1'b0;
        bus.ld_rsp_rdy = 1'b0;
        bus.ld_req_vld = 1'b1;
        bus.ld_req_idx = 11'h005;
        tick();
        bus.ld_req_idx = 11'h006;
        tick();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_vld", bus.ld_rsp_vld, 0);
        tick();
        rst = 1'b0;
        bus.ld_rsp_rdy = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.ld_rsp_vld) seen++;
            tick();
        end
        check("post_rst_no_rsp", seen, 0);

        // Randomized mix with colliding indices.
        for (int c = 0; c < 400; c++) begin
            bus.ld_req_vld = ($urandom_range(0, 99) < 60);
            bus.ld_req_idx = 11'h40 + 11'($urandom_range(0, 7));
            bus.st_req_vld = ($urandom_range(0, 99) < 35);
            bus.st_req_idx = 11'h40 + 11'($urandom_range(0, 7));
            bus.st_req_din = $urandom;
            bus.st_req_be  = 4'($urandom_range(0, 15));
            bus.ld_rsp_rdy = ($urandom_range(0, 99) < 70);
            tick();
        end
        idle_inputs();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ct_lsu_dcache_data_ctrl.md
CT_LSU_DCACHE_DATA_CTRL -- requirements
Module: ct_lsu_dcache_data_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 forever_cpuclk  in  1  clock, rising edge.
REQ-003 cpurst  in  1  asynchronous active-high reset.
REQ-004 ld_req_vld / ld_req_idx  in  1/11  load read request and word index.
REQ-005 ld_req_rdy  out  1  load request accepted this cycle when high with ld_req_vld.
REQ-006 st_req_vld / st_req_idx / st_req_din / st_req_be  in  1/11/32/4  write request, index, data, byte enables (active-high).
REQ-007 st_req_rdy  out  1  store request accepted this cycle.
REQ-008 data_gateclk_en / data_sel_b / data_gwen_b  out  1/1/1  array clock enable, chip select (low), global write enable (low).
REQ-009 data_wen_b / data_idx / data_din  out  4/11/32  byte write enables (low), index, write data.
REQ-010 data_dout  in  32  array read data, valid the cycle after a read select.
REQ-011 ld_rsp_vld / ld_rsp_data  out  1/32  load response; ld_rsp_rdy  in  1  consumer accept.

Function
REQ-012 At most one array access per cycle; the array control outputs are combinational from the current-cycle grant.
REQ-013 Store grant: data_gateclk_en=1, data_sel_b=0, data_gwen_b=0, data_wen_b=~st_req_be, data_idx=st_req_idx, data_din=st_req_din.
REQ-014 Load grant: data_gateclk_en=1, data_sel_b=0, data_gwen_b=1, data_wen_b=4'hF, data_idx=ld_req_idx.
REQ-015 No grant: data_gateclk_en=0, data_sel_b=1, data_gwen_b=1, data_wen_b=4'hF; data_idx/data_din=0.
REQ-016 Store with st_req_be=0 SHALL still be accepted but SHALL NOT select the array (treated as no access; the load may be granted that cycle).
REQ-017 A read in flight (1-bit register) SHALL be set at the load grant edge; data_dout SHALL be pushed into a 2-entry response FIFO on the following edge.
REQ-018 Load latency: accepted at cycle T -> ld_rsp_vld asserted at T+2 with that data; responses in request order.
REQ-019 Credit = FIFO occupancy + in-flight flag (0..3 range, never >2); load is eligible only when credit<2, or credit==2 and a FIFO pop (ld_rsp_vld & ld_rsp_rdy) occurs this cycle.
REQ-020 With ld_rsp_rdy held high, back-to-back loads SHALL sustain one accept per cycle.
REQ-021 ld_rsp_vld/ld_rsp_data SHALL hold stable until accepted; simultaneous push and pop at occupancy 2 SHALL not occur (guaranteed by credit).
REQ-022 Arbitration: store has priority over an eligible load unless the starvation guard (REQ-026) forces the load.
REQ-023 Load and store to the same index in the same cycle: store wins; the load is re-presented by the requester and returns post-write data.

Reset
REQ-024 While cpurst=1: ld_req_rdy=0, st_req_rdy=0, ld_rsp_vld=0, ld_rsp_data=0, array outputs at REQ-015 idle values; FIFO, in-flight flag and starvation counter cleared.
REQ-025 Reset asserted mid-operation SHALL discard in-flight reads and buffered responses; no response is produced for them after release.

Configuration
REQ-026 Macro LSU_DCACHE_STARVE_GUARD_EN defined: 2-bit counter increments each cycle a store is granted while an eligible load waits; at count 3 the next eligible load is granted over a store and the counter clears; any load grant clears it.
REQ-027 Macro undefined: strict store priority, no counter present; loads may starve indefinitely.

Structure
REQ-028 Shared package holds index width (11), data width (32), byte-enable width (4), FIFO depth (2) and starve threshold (3).
REQ-029 One sub-module ct_lsu_dcache_rsp_fifo (2-entry, valid/ready, occupancy output); arbitration and credit logic stay in the top.

Verification
REQ-030 Single load idx=0x155 after a store of 0xDEADBEEF, be=4'hF -> ld_rsp_vld at T+2, ld_rsp_data=0xDEADBEEF.
REQ-031 Store be=4'b0101 data 0x11223344 over 0xAAAAAAAA -> data_wen_b=4'b1010; subsequent load returns 0xAA22AA44.
REQ-032 8 back-to-back loads, ld_rsp_rdy=1 -> ld_req_rdy high every cycle, 8 in-order responses starting at T+2.
REQ-033 ld_rsp_rdy=0, loads continuous -> exactly 2 accepted, ld_req_rdy=0 afterwards; release -> resumes one per cycle, no data lost.
REQ-034 Continuous stores plus pending load, macro defined -> load granted on 4th cycle; macro undefined -> load never granted.
REQ-035 cpurst pulsed 1 cycle with one read in flight and one buffered -> ld_rsp_vld=0 and no response after release.
